// File: rtl/fcs_check.sv
// Receive-side serial CRC-16 (x^16+x^12+x^5+1) FCS checker for 802.15.4 PSDUs.
// Consumes payload bits, then 16 FCS bits MSB first, and reports match/length error.
module fcs_check (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  len,
    input  logic        valid,
    input  logic        data,
    output logic        busy,
    output logic        done,
    output logic        fcs_ok,
    output logic        len_error,
    output logic [15:0] rx_fcs,
    output logic [15:0] calc_fcs
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned CRC_W   = 16;
    localparam int unsigned MIN_LEN = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_FCS     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [CRC_W-1:0]   r_crc;
    logic [CRC_W-1:0]   r_rx_sh;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_fb;
    logic [CRC_W-1:0]   w_crc_next;
    logic [CRC_W-1:0]   w_rx_next;
    logic               w_len_ok;
    logic [CNT_W-1:0]   w_cnt_load;

    // Galois-form CRC step; taps at bits 12 and 5 plus the feedback into bit 0
    assign w_fb       = data ^ r_crc[15];
    assign w_crc_next = {r_crc[14:12], r_crc[11] ^ w_fb, r_crc[10:5],
                         r_crc[4] ^ w_fb, r_crc[3:0], w_fb};
    assign w_rx_next  = {r_rx_sh[14:0], data};
    assign w_len_ok   = (len >= 7'(MIN_LEN));
    // (len-2)*8-1 == 8*len - 17
    assign w_cnt_load = {len, 3'b000} - CNT_W'(17);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_crc     <= '0;
            r_rx_sh   <= '0;
            r_cnt     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fcs_ok    <= 1'b0;
            len_error <= 1'b0;
            rx_fcs    <= '0;
            calc_fcs  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                // A new start always wins: aborts any frame and ignores this cycle's bit
                r_crc   <= '0;
                r_rx_sh <= '0;
                fcs_ok  <= 1'b0;
                if (w_len_ok) begin
                    r_state   <= S_PAYLOAD;
                    r_cnt     <= w_cnt_load;
                    busy      <= 1'b1;
                    len_error <= 1'b0;
                end else begin
                    r_state   <= S_DONE;
                    r_cnt     <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    len_error <= 1'b1;
                    rx_fcs    <= '0;
                    calc_fcs  <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_PAYLOAD: begin
                        if (valid) begin
                            r_crc <= w_crc_next;
                            if (r_cnt == '0) begin
                                r_state <= S_FCS;
                                r_cnt   <= CNT_W'(15);
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    S_FCS: begin
                        if (valid) begin
                            r_rx_sh <= w_rx_next;
                            if (r_cnt == '0) begin
                                r_state   <= S_DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                fcs_ok    <= (w_rx_next == r_crc);
                                calc_fcs  <= r_crc;
                                rx_fcs    <= w_rx_next;
                                len_error <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fcs_check.sv
// Bench for fcs_check: directed table, randomized frames against a polynomial-division
// CRC model, plus abort and mid-frame reset sequences.
module tb_fcs_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  len;
    logic        valid;
    logic        data;
    logic        busy;
    logic        done;
    logic        fcs_ok;
    logic        len_error;
    logic [15:0] rx_fcs;
    logic [15:0] calc_fcs;

    fcs_check dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .valid     (valid),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .fcs_ok    (fcs_ok),
        .len_error (len_error),
        .rx_fcs    (rx_fcs),
        .calc_fcs  (calc_fcs)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    bit q_pay[$];
    bit q_bits[$];
    int f_ndone;
    int f_done_cyc;
    int f_c0;
    int f_stalls;
    int f_nbits;
    bit f_busy_bad;

    typedef struct {
        logic [6:0]  len;
        int          mode;
        logic [15:0] fcs;
        int          stall;
        logic [15:0] e_calc;
        logic [15:0] e_rx;
        logic        e_ok;
        logic        e_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC as remainder of M(x)*x^16 mod G(x) by long division over the augmented message
    function automatic logic [15:0] ref_crc();
        logic [16:0] r;
        r = '0;
        foreach (q_pay[i]) begin
            r = {r[15:0], q_pay[i]};
            if (r[16]) r = r ^ 17'h11021;
        end
        for (int i = 0; i < 16; i++) begin
            r = {r[15:0], 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    // mode 0: all zeros, 1: zeros ending in a single 1, 2: random
    task automatic make_pay(input int l, input int mode);
        int nb;
        q_pay.delete();
        nb = (l >= 5) ? (l - 2) * 8 : 0;
        for (int i = 0; i < nb; i++) begin
            if (mode == 0)      q_pay.push_back(1'b0);
            else if (mode == 1) q_pay.push_back(i == nb - 1);
            else                q_pay.push_back(1'($urandom_range(1)));
        end
    endtask

    task automatic run_frame(input logic [6:0] l, input logic [15:0] fcs, input int stall_pct);
        int idx;
        int post;
        bit legal;
        legal = (l >= 7'd5);
        q_bits = q_pay;
        if (legal) for (int i = 15; i >= 0; i--) q_bits.push_back(fcs[i]);
        f_nbits = q_bits.size();
        f_ndone = 0;
        f_done_cyc = -1;
        f_stalls = 0;
        f_busy_bad = 0;
        idx = 0;
        post = 0;
        @(negedge clk);
        start = 1'b1;
        len   = l;
        valid = 1'b1;
        data  = 1'b1;
        f_c0  = cyc;
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 0) begin
                chk("busy_after_start", busy, legal);
                chk("fcs_ok_clear_after_start", fcs_ok, 1'b0);
                chk("len_error_after_start", len_error, !legal);
            end
            if (done) begin
                f_ndone++;
                f_done_cyc = cyc;
            end
            if (legal && idx < f_nbits && !busy) f_busy_bad = 1;
            if (!legal && busy) f_busy_bad = 1;
            if (idx < f_nbits) begin
                if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                    valid = 1'b0;
                    data  = 1'($urandom_range(1));
                    f_stalls++;
                end else begin
                    valid = 1'b1;
                    data  = q_bits[idx];
                    idx++;
                end
            end else begin
                valid = 1'b0;
                post++;
                if (post > 3) break;
            end
        end
        valid = 1'b0;
        chk("frame_bits_sent", idx, f_nbits);
    endtask

    task automatic check_result(input string tag, input logic [15:0] e_calc, input logic [15:0] e_rx,
                                input logic e_ok, input logic e_err);
        chk({tag, "_done_count"}, f_ndone, 1);
        chk({tag, "_done_cycle"}, f_done_cyc, f_c0 + f_nbits + f_stalls + 1);
        chk({tag, "_busy_ok"}, f_busy_bad, 1'b0);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_calc_fcs"}, calc_fcs, e_calc);
        chk({tag, "_rx_fcs"}, rx_fcs, e_rx);
        chk({tag, "_fcs_ok"}, fcs_ok, e_ok);
        chk({tag, "_len_error"}, len_error, e_err);
    endtask

    initial begin
        int nd;
        logic [6:0]  l;
        logic [15:0] crc;
        logic [15:0] fcs;
        bit legal;

        tbl[0] = '{7'd5, 0, 16'h0000, 0,  16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{7'd5, 1, 16'h1021, 30, 16'h1021, 16'h1021, 1'b1, 1'b0};
        tbl[2] = '{7'd5, 1, 16'h1020, 0,  16'h1021, 16'h1020, 1'b0, 1'b0};
        tbl[3] = '{7'd3, 0, 16'h1234, 0,  16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{7'd5, 0, 16'h0000, 10, 16'h0000, 16'h0000, 1'b1, 1'b0};
        tbl[5] = '{7'd0, 0, 16'hFFFF, 0,  16'h0000, 16'h0000, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; len = '0; valid = 1'b0; data = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_fcs_ok", fcs_ok, 1'b0);
        chk("reset_len_error", len_error, 1'b0);
        chk("reset_rx_fcs", rx_fcs, 16'h0000);
        chk("reset_calc_fcs", calc_fcs, 16'h0000);

        for (int i = 0; i < 6; i++) begin
            make_pay(int'(tbl[i].len), tbl[i].mode);
            run_frame(tbl[i].len, tbl[i].fcs, tbl[i].stall);
            check_result($sformatf("vec%0d", i), tbl[i].e_calc, tbl[i].e_rx, tbl[i].e_ok, tbl[i].e_err);
        end

        // abort a long frame after 100 bits with a fresh minimum-length start
        @(negedge clk);
        start = 1'b1; len = 7'd127; valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            valid = 1'b1;
            data  = 1'($urandom_range(1));
            @(negedge clk);
            if (done) nd++;
        end
        valid = 1'b0;
        chk("abort_busy_midframe", busy, 1'b1);
        chk("abort_no_done", nd, 0);
        make_pay(5, 0);
        run_frame(7'd5, 16'h0000, 0);
        check_result("abort", 16'h0000, 16'h0000, 1'b1, 1'b0);

        // randomized frames against the division model
        for (int r = 0; r < 10; r++) begin
            l = ($urandom_range(7) == 0) ? 7'($urandom_range(4)) : 7'($urandom_range(12, 5));
            legal = (l >= 7'd5);
            make_pay(int'(l), 2);
            crc = ref_crc();
            fcs = ($urandom_range(1) == 1) ? crc : 16'($urandom);
            run_frame(l, fcs, 20);
            check_result($sformatf("rand%0d", r), legal ? crc : 16'h0000, legal ? fcs : 16'h0000,
                         legal && (fcs == crc), !legal);
        end

        // reset in the middle of the FCS field
        make_pay(5, 1);
        run_frame(7'd5, 16'h1021, 0);
        check_result("pre_rst", 16'h1021, 16'h1021, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; len = 7'd5; valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            valid = 1'b1;
            data  = (i < 24) ? q_pay[i] : 1'b1;
            @(negedge clk);
        end
        rst = 1'b1; valid = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_fcs_ok", fcs_ok, 1'b0);
        chk("rst_len_error", len_error, 1'b0);
        chk("rst_rx_fcs", rx_fcs, 16'h0000);
        chk("rst_calc_fcs", calc_fcs, 16'h0000);
        rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            valid = 1'b1;
            data  = 1'($urandom_range(1));
            @(negedge clk);
            if (done || busy) nd++;
        end
        valid = 1'b0;
        chk("rst_no_done_after", nd, 0);
        make_pay(6, 2);
        crc = ref_crc();
        run_frame(7'd6, crc, 15);
        check_result("post_rst", crc, crc, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
